// File: rtl/regfile_seq_pkg.sv
// Shared definitions for regfile_seq: default widths, ALU op encodings, FSM states.
package regfile_seq_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned OP_W       = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the S2 stage: unsigned wrap-around ADD/SUB, bitwise AND/XOR.
module regfile_seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  op_e               op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/regfile_seq.sv
// Two-stage command sequencer over an external sync-read 2R1W register file.
// Define REGFILE_SEQ_FORWARD_EN to replace RAW stalls with S2->S2 result forwarding.
module regfile_seq
  import regfile_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0] rf_rd_addr1,
  output logic [ADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0] rf_rd_data1,
  input  logic [DATA_W-1:0] rf_rd_data2,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic              rf_wen
);

  localparam int unsigned LAST_ADDR = (1 << ADDR_W) - 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              s2_valid_q, s2_valid_d;
  op_e               s2_op_q, s2_op_d;
  logic [ADDR_W-1:0] s2_rd_q, s2_rd_d;

  logic              hazard_stall;
  logic              ready_c;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b, alu_res;

  // Read addresses go straight to the RF so data lands in S2 one edge later
  assign rf_rd_addr1 = cmd_rs1;
  assign rf_rd_addr2 = cmd_rs2;

`ifdef REGFILE_SEQ_FORWARD_EN
  logic              fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [DATA_W-1:0] fwd_data_q;

  assign hazard_stall = 1'b0;
  assign op_a = fwd1_q ? fwd_data_q : rf_rd_data1;
  assign op_b = fwd2_q ? fwd_data_q : rf_rd_data2;

  // A match means the RF read raced the prior S2 write; use its result instead
  always_comb begin
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    if (accept) begin
      fwd1_d = s2_valid_q && (cmd_rs1 == s2_rd_q);
      fwd2_d = s2_valid_q && (cmd_rs2 == s2_rd_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd1_q <= fwd1_d;
      fwd2_q <= fwd2_d;
      if (s2_valid_q) fwd_data_q <= alu_res;
    end
  end
`else
  assign hazard_stall = cmd_valid && s2_valid_q &&
                        ((cmd_rs1 == s2_rd_q) || (cmd_rs2 == s2_rd_q));
  assign op_a = rf_rd_data1;
  assign op_b = rf_rd_data2;
`endif

  assign ready_c = (state_q == ST_RUN) && !rst && !hazard_stall;
  assign accept  = cmd_valid && ready_c;

  regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i  (s2_op_q),
    .a_i   (op_a),
    .b_i   (op_b),
    .res_o (alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR;
      clr_cnt_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_op_q    <= OP_ADD;
      s2_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      s2_valid_q <= s2_valid_d;
      s2_op_q    <= s2_op_d;
      s2_rd_q    <= s2_rd_d;
    end
  end

  // Next state, S1 capture and S2 writeback; rst masks every strobe at once
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    s2_valid_d = 1'b0;
    s2_op_d    = s2_op_q;
    s2_rd_d    = s2_rd_q;
    cmd_ready  = ready_c;
    res_valid  = 1'b0;
    res_data   = '0;
    rf_wen     = 1'b0;
    rf_wr_addr = s2_rd_q;
    rf_wr_data = alu_res;

    case (state_q)
      ST_CLEAR: begin
        rf_wen     = 1'b1;
        rf_wr_addr = clr_cnt_q;
        rf_wr_data = '0;
        clr_cnt_d  = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(LAST_ADDR)) begin
          clr_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (s2_valid_q) begin
          rf_wen    = 1'b1;
          res_valid = 1'b1;
          res_data  = alu_res;
        end
        if (accept) begin
          s2_valid_d = 1'b1;
          s2_op_d    = op_e'(cmd_op);
          s2_rd_d    = cmd_rd;
        end
      end
      default: state_d = ST_CLEAR;
    endcase

    if (rst) begin
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      res_data  = '0;
      rf_wen    = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq paired with a behavioural read-first 2R1W register file.
module tb_regfile_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 5;
  localparam int unsigned NREG = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic [31:0]   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] rf_rd_addr1, rf_rd_addr2, rf_wr_addr;
  logic [DW-1:0] rf_rd_data1, rf_rd_data2, rf_wr_data;
  logic          rf_wen;

  logic          bd_wen;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] mem   [NREG];
  logic [DW-1:0] model [NREG];
  exp_t          q[$];
  logic [31:0]   cyc = 32'd0;
  int            vectors = 0;
  int            miscompares = 0;
  int            stall_cnt = 0;

  regfile_seq dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_rd      (cmd_rd),
    .cmd_rs1     (cmd_rs1),
    .cmd_rs2     (cmd_rs2),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .rf_rd_addr1 (rf_rd_addr1),
    .rf_rd_addr2 (rf_rd_addr2),
    .rf_rd_data1 (rf_rd_data1),
    .rf_rd_data2 (rf_rd_data2),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .rf_wen      (rf_wen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Read-first register file; the backdoor port only preloads while the DUT is idle
  always @(posedge clk) begin
    rf_rd_data1 <= mem[rf_rd_addr1];
    rf_rd_data2 <= mem[rf_rd_addr2];
    if (rf_wen === 1'b1) mem[rf_wr_addr] <= rf_wr_data;
    else if (bd_wen) mem[bd_addr] <= bd_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_op(input logic [1:0] op, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      2'd0:    return DW'(a + b);
      2'd1:    return DW'(a - b);
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_wen  = 1'b1;
    bd_addr = a;
    bd_data = d;
    @(posedge clk);
    @(negedge clk);
    bd_wen   = 1'b0;
    model[a] = d;
  endtask

  // Presents one command, waits (bounded) for the handshake, records the expected result
  task automatic send(input logic [1:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                      input logic [AW-1:0] rs2, input bit use_exp, input logic [DW-1:0] exp);
    int   waited;
    logic [DW-1:0] r;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    #1;
    waited = 0;
    while (cmd_ready !== 1'b1 && waited < 20) begin
      stall_cnt++;
      waited++;
      @(negedge clk);
      #1;
    end
    if (cmd_ready !== 1'b1) begin
      chk("ready_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    r         = ref_op(op, model[rs1], model[rs2]);
    model[rd] = r;
    e.data    = use_exp ? exp : r;
    e.rd      = rd;
    e.cyc     = cyc + 32'd1;
    q.push_back(e);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic clear_check();
    rst = 1'b0;
    for (int i = 0; i < int'(NREG); i++) begin
      #1;
      chk("clr_ready", 32'(cmd_ready), 32'd0);
      chk("clr_wen", 32'(rf_wen), 32'd1);
      chk("clr_addr", 32'(rf_wr_addr), 32'(i));
      chk("clr_data", 32'(rf_wr_data), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("clr_done_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < int'(NREG); i++) model[i] = '0;
  endtask

  // Monitor: every result strobe must match the oldest outstanding expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (res_valid === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_res", 32'(res_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("res_data", 32'(res_data), 32'(e.data));
          chk("res_latency", cyc, e.cyc);
          chk("wr_en", 32'(rf_wen), 32'd1);
          chk("wr_addr", 32'(rf_wr_addr), 32'(e.rd));
          chk("wr_data", 32'(rf_wr_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]    rop;
    logic [AW-1:0] rrd, ra, rb;
    int            exp_stalls;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    bd_wen    = 1'b0;
    bd_addr   = '0;
    bd_data   = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_wen", 32'(rf_wen), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    clear_check();

    for (int i = 0; i < int'(NREG); i++) preload(AW'(i), DW'($urandom));

    // Wrap-around ADD and SUB
    preload(5'd1, 8'h05);
    preload(5'd2, 8'hFE);
    send(2'd0, 5'd3, 5'd1, 5'd2, 1'b1, 8'h03);
    send(2'd1, 5'd4, 5'd1, 5'd2, 1'b1, 8'h07);
    idle(2);

    // Four independent commands back to back
    stall_cnt = 0;
    send(2'd0, 5'd10, 5'd11, 5'd12, 1'b0, 8'h00);
    send(2'd1, 5'd13, 5'd14, 5'd15, 1'b0, 8'h00);
    send(2'd2, 5'd16, 5'd17, 5'd18, 1'b0, 8'h00);
    send(2'd3, 5'd19, 5'd20, 5'd21, 1'b0, 8'h00);
    chk("b2b_stalls", 32'(stall_cnt), 32'd0);
    idle(2);

    // RAW dependency on the immediately preceding result
    preload(5'd2, 8'h03);
    stall_cnt = 0;
    send(2'd3, 5'd5, 5'd1, 5'd2, 1'b1, 8'h06);
    send(2'd0, 5'd6, 5'd5, 5'd1, 1'b1, 8'h0B);
`ifdef REGFILE_SEQ_FORWARD_EN
    exp_stalls = 0;
`else
    exp_stalls = 1;
`endif
    chk("raw_stalls", 32'(stall_cnt), 32'(exp_stalls));
    idle(2);

    // Same destination, no source overlap: must not stall
    stall_cnt = 0;
    send(2'd0, 5'd7, 5'd1, 5'd2, 1'b0, 8'h00);
    send(2'd1, 5'd7, 5'd2, 5'd1, 1'b0, 8'h00);
    chk("waw_stalls", 32'(stall_cnt), 32'd0);
    idle(2);

    // Randomised traffic with a bias toward low registers to provoke hazards
    for (int n = 0; n < 300; n++) begin
      rop = 2'($urandom);
      rrd = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      rb  = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
      send(rop, rrd, ra, rb, 1'b0, 8'h00);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    // Reset while an op sits in S2: no write may escape, then a full clear
    send(2'd0, 5'd8, 5'd1, 5'd2, 1'b0, 8'h00);
    rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_wen", 32'(rf_wen), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge clk);
    clear_check();
    for (int i = 0; i < int'(NREG); i++) send(2'd0, AW'(i), AW'(i), AW'(i), 1'b1, 8'h00);

    idle(4);
    chk("queue_drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
